// File: rtl/shift_led_pkg.sv
// Shared defaults, FSM encoding and helpers for the rotating-LED monitor.
package shift_led_pkg;

    localparam int N_LEDS_DEF   = 4;
    localparam int NB_SEL_DEF   = 2;
    localparam int NB_COUNT_DEF = 32;
    localparam int NB_ERR_DEF   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        TRACK = 2'd2
    } mon_state_t;

    // Expected dwell for a limit select: 2^(nb_count-10+sel) cycles.
    function automatic logic [63:0] period_of(input int nb_count, input int sel);
        return 64'd1 << (nb_count - 10 + sel);
    endfunction

    // Rotate-left of the low `width` bits of led.
    function automatic logic [31:0] rotl(input logic [31:0] led, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++)
            if (i < width) r[(i + 1) % width] = led[i];
        return r;
    endfunction

endpackage

// File: rtl/shift_led_monitor_sat_counter.sv
// Saturating up-counter with variable increment; clear beats increment.
module sat_counter #(
    parameter int W     = 16,
    parameter int INC_W = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic [INC_W-1:0] inc,
    output logic [W-1:0]     count
);

    logic [W:0] sum;

    always_comb sum = {1'b0, count} + (W+1)'(inc);

    always_ff @(posedge clock) begin
        if (!reset)      count <= '0;
        else if (clr)    count <= '0;
        else if (sum[W]) count <= '1;
        else             count <= sum[W-1:0];
    end

endmodule

// File: rtl/shift_led_monitor.sv
// Receive-side checker for the rotating one-hot LED pattern: content,
// rotate-left order and dwell period, with sticky flags and counters.
module shift_led_monitor
    import shift_led_pkg::*;
#(
    parameter int N_LEDS   = N_LEDS_DEF,
    parameter int NB_SEL   = NB_SEL_DEF,
    parameter int NB_COUNT = NB_COUNT_DEF,
    parameter int NB_ERR   = NB_ERR_DEF
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic [N_LEDS-1:0]   i_led,
    input  logic                i_enable,
    input  logic [NB_SEL-1:0]   i_sel,
    input  logic                i_clear,
    output logic                o_locked,
    output logic [NB_COUNT-1:0] o_dwell,
    output logic                o_err_onehot,
    output logic                o_err_dir,
    output logic                o_err_period,
    output logic [NB_ERR-1:0]   o_err_count,
    output logic [NB_ERR-1:0]   o_shift_count
);

    mon_state_t          state, state_nxt;
    logic [N_LEDS-1:0]   led_q, led_prev, led_exp;
    logic [NB_SEL-1:0]   sel_q;
    logic [NB_COUNT-1:0] cnt;
    logic [NB_COUNT:0]   dwell_len, period;
    logic                bad, bad_q, reported;
    logic                change, sel_chg, dir_ok;
    logic                onehot_evt, dir_evt, shift_evt, period_evt, stall_evt;
    logic                lock_set, lock_drop;
    logic [1:0]          err_inc;

    always_comb begin
        led_exp   = N_LEDS'(rotl(32'(led_prev), N_LEDS));
        period    = (NB_COUNT+1)'(period_of(NB_COUNT, int'(i_sel)));
        dwell_len = {1'b0, cnt} + (NB_COUNT+1)'(1);
        change    = led_q != led_prev;
        sel_chg   = i_sel != sel_q;
        dir_ok    = led_q == led_exp;
        // An all-zero bus before the first pattern is an undriven bus, not a fault.
        bad        = !$onehot(led_q) && !(state == IDLE && led_q == '0);
        onehot_evt = bad && !bad_q;
        dir_evt    = change && state != IDLE && !dir_ok;
        shift_evt  = change && state != IDLE && dir_ok;
    end

    always_comb begin
        state_nxt  = state;
        period_evt = 1'b0;
        stall_evt  = 1'b0;
        lock_set   = 1'b0;
        lock_drop  = 1'b0;
        case (state)
            IDLE:  if (change) state_nxt = SYNC;
            SYNC:  if (change) state_nxt = TRACK;
            TRACK: if (!sel_chg) begin
                // A dwell already flagged as a stall is not counted again at its end.
                if (change) begin
                    if (dwell_len == period) lock_set = 1'b1;
                    else begin
                        lock_drop  = 1'b1;
                        period_evt = !reported;
                    end
                end else if (dwell_len > period && !reported) begin
                    stall_evt = 1'b1;
                    lock_drop = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE && (dir_evt || sel_chg)) begin
            state_nxt = SYNC;
            lock_set  = 1'b0;
            lock_drop = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            led_q        <= '0;
            led_prev     <= '0;
            sel_q        <= '0;
            bad_q        <= 1'b0;
            reported     <= 1'b0;
            cnt          <= '0;
            o_dwell      <= '0;
            o_locked     <= 1'b0;
            o_err_onehot <= 1'b0;
            o_err_dir    <= 1'b0;
            o_err_period <= 1'b0;
        end else begin
            led_q    <= i_led;
            led_prev <= led_q;
            sel_q    <= i_sel;
            bad_q    <= bad;
            if (change) begin
                o_dwell  <= dwell_len[NB_COUNT-1:0];
                cnt      <= '0;
                reported <= 1'b0;
            end else begin
                if (i_enable && cnt != '1) cnt <= cnt + NB_COUNT'(1);
                if (stall_evt) reported <= 1'b1;
            end
            if (i_clear) begin
                o_locked     <= 1'b0;
                o_err_onehot <= 1'b0;
                o_err_dir    <= 1'b0;
                o_err_period <= 1'b0;
            end else begin
                if (onehot_evt)              o_err_onehot <= 1'b1;
                if (dir_evt)                 o_err_dir    <= 1'b1;
                if (period_evt || stall_evt) o_err_period <= 1'b1;
                if (lock_drop)               o_locked     <= 1'b0;
                else if (lock_set)           o_locked     <= 1'b1;
            end
        end
    end

    always_comb err_inc = {1'b0, onehot_evt} + {1'b0, dir_evt} + {1'b0, period_evt | stall_evt};

    sat_counter #(.W(NB_ERR), .INC_W(2)) u_err_cnt (
        .clock (clock),
        .reset (i_reset),
        .clr   (i_clear),
        .inc   (err_inc),
        .count (o_err_count)
    );

    sat_counter #(.W(NB_ERR), .INC_W(1)) u_shift_cnt (
        .clock (clock),
        .reset (i_reset),
        .clr   (i_clear),
        .inc   (shift_evt),
        .count (o_shift_count)
    );

endmodule
